// File: rtl/uart_line_buffer.sv
// Line assembler between the uart RX stream and the command parser: backspace editing,
// overlong-line dropping, one AXI-Stream packet per line. Terminal echo is built only with UART_LINE_ECHO_EN.
module uart_line_buffer #(
  parameter int MAX_LEN = 32,
  parameter int PTR_W   = 6
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tvalid,
  output logic       s_axis_tready,
  output logic [7:0] m_axis_tdata,
  output logic       m_axis_tvalid,
  input  logic       m_axis_tready,
  output logic       m_axis_tlast,
  output logic [7:0] echo_axis_tdata,
  output logic       echo_axis_tvalid,
  input  logic       echo_axis_tready,
  output logic       overflow,
  output logic       busy
);

  localparam int AW = $clog2(MAX_LEN);
  localparam logic [1:0] ST_COLLECT = 2'd0;
  localparam logic [1:0] ST_FLUSH   = 2'd1;
  localparam logic [1:0] ST_DROP    = 2'd2;
  localparam logic [PTR_W-1:0] MAX_PTR = PTR_W'(MAX_LEN);
  localparam logic [PTR_W-1:0] ONE     = PTR_W'(1);

  logic [1:0]       state_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] len_reg;
  logic [PTR_W-1:0] rd_ptr_next;
  logic             ready_en_reg;
  logic [7:0]       m_data_reg;
  logic             m_valid_reg;
  logic             m_last_reg;
  logic             overflow_reg;
  logic [7:0]       buf_mem [MAX_LEN];

  logic s_fire;
  logic m_fire;
  logic is_print;
  logic is_bs;
  logic is_eol;
  logic buf_we;
  logic echo_empty;

  assign is_print = (s_axis_tdata >= 8'h20) && (s_axis_tdata <= 8'h7E);
  assign is_bs    = (s_axis_tdata == 8'h08) || (s_axis_tdata == 8'h7F);
  assign is_eol   = (s_axis_tdata == 8'h0D) || (s_axis_tdata == 8'h0A);

  // ready_en_reg keeps s_axis_tready low until the first edge after reset release
  assign s_axis_tready = ready_en_reg && echo_empty &&
                         ((state_reg == ST_COLLECT) || (state_reg == ST_DROP));
  assign s_fire      = s_axis_tvalid && s_axis_tready;
  assign m_fire      = m_valid_reg && m_axis_tready;
  assign rd_ptr_next = rd_ptr_reg + ONE;
  assign buf_we      = s_fire && (state_reg == ST_COLLECT) && is_print && (wr_ptr_reg != MAX_PTR);

  assign m_axis_tdata  = m_data_reg;
  assign m_axis_tvalid = m_valid_reg;
  assign m_axis_tlast  = m_last_reg;
  assign overflow      = overflow_reg;
  assign busy          = (state_reg == ST_FLUSH) || (state_reg == ST_DROP);

  always_ff @(posedge clk) begin
    if (buf_we) begin
      buf_mem[wr_ptr_reg[AW-1:0]] <= s_axis_tdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= ST_COLLECT;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      len_reg      <= '0;
      ready_en_reg <= 1'b0;
      m_data_reg   <= 8'h00;
      m_valid_reg  <= 1'b0;
      m_last_reg   <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      ready_en_reg <= 1'b1;
      overflow_reg <= 1'b0;
      case (state_reg)
        ST_COLLECT: begin
          if (s_fire) begin
            if (is_print) begin
              if (wr_ptr_reg == MAX_PTR) begin
                state_reg <= ST_DROP;
              end else begin
                wr_ptr_reg <= wr_ptr_reg + ONE;
              end
            end else if (is_bs) begin
              if (wr_ptr_reg != '0) begin
                wr_ptr_reg <= wr_ptr_reg - ONE;
              end
            end else if (is_eol && (wr_ptr_reg != '0)) begin
              // Preload the first byte so the packet starts the cycle after the terminator
              len_reg     <= wr_ptr_reg;
              rd_ptr_reg  <= '0;
              m_data_reg  <= buf_mem[0];
              m_valid_reg <= 1'b1;
              m_last_reg  <= (wr_ptr_reg == ONE);
              state_reg   <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          if (m_fire) begin
            if (m_last_reg) begin
              m_valid_reg <= 1'b0;
              m_last_reg  <= 1'b0;
              m_data_reg  <= 8'h00;
              rd_ptr_reg  <= '0;
              wr_ptr_reg  <= '0;
              state_reg   <= ST_COLLECT;
            end else begin
              rd_ptr_reg <= rd_ptr_next;
              m_data_reg <= buf_mem[rd_ptr_next[AW-1:0]];
              m_last_reg <= (rd_ptr_next == (len_reg - ONE));
            end
          end
        end
        ST_DROP: begin
          if (s_fire && is_eol) begin
            overflow_reg <= 1'b1;
            wr_ptr_reg   <= '0;
            state_reg    <= ST_COLLECT;
          end
        end
        default: state_reg <= ST_COLLECT;
      endcase
    end
  end

`ifdef UART_LINE_ECHO_EN
  logic [7:0] echo_q_reg [3];
  logic [7:0] echo_shift [3];
  logic [1:0] echo_cnt_reg;
  logic       echo_load;
  logic [1:0] echo_load_cnt;
  logic [7:0] echo_load_data [3];
  logic       echo_fire;

  assign echo_empty       = (echo_cnt_reg == 2'd0);
  assign echo_axis_tvalid = !echo_empty;
  assign echo_axis_tdata  = echo_q_reg[0];
  assign echo_fire        = echo_axis_tvalid && echo_axis_tready;

  for (genvar gi = 0; gi < 3; gi++) begin : g_echo_shift
    if (gi < 2) begin : g_mid
      assign echo_shift[gi] = echo_q_reg[gi+1];
    end else begin : g_tail
      assign echo_shift[gi] = 8'h00;
    end
  end

  // Loads only happen while the queue is empty, so load and drain never collide
  always_comb begin
    echo_load     = 1'b0;
    echo_load_cnt = 2'd0;
    for (int i = 0; i < 3; i++) echo_load_data[i] = 8'h00;
    if (s_fire && (state_reg == ST_COLLECT)) begin
      if (is_print && (wr_ptr_reg != MAX_PTR)) begin
        echo_load         = 1'b1;
        echo_load_cnt     = 2'd1;
        echo_load_data[0] = s_axis_tdata;
      end else if (is_bs && (wr_ptr_reg != '0)) begin
        echo_load         = 1'b1;
        echo_load_cnt     = 2'd3;
        echo_load_data[0] = 8'h08;
        echo_load_data[1] = 8'h20;
        echo_load_data[2] = 8'h08;
      end else if (is_eol && (wr_ptr_reg != '0)) begin
        echo_load         = 1'b1;
        echo_load_cnt     = 2'd2;
        echo_load_data[0] = 8'h0D;
        echo_load_data[1] = 8'h0A;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      echo_cnt_reg <= 2'd0;
      for (int i = 0; i < 3; i++) echo_q_reg[i] <= 8'h00;
    end else if (echo_load) begin
      echo_cnt_reg <= echo_load_cnt;
      for (int i = 0; i < 3; i++) echo_q_reg[i] <= echo_load_data[i];
    end else if (echo_fire) begin
      echo_cnt_reg <= echo_cnt_reg - 2'd1;
      for (int i = 0; i < 3; i++) echo_q_reg[i] <= echo_shift[i];
    end
  end
`else
  logic unused_echo_tready;

  assign unused_echo_tready = echo_axis_tready;
  assign echo_empty         = 1'b1;
  assign echo_axis_tvalid   = 1'b0;
  assign echo_axis_tdata    = 8'h00;
`endif

endmodule

// File: tb/tb_uart_line_buffer.sv
// Self-checking bench for uart_line_buffer: queue-based line model, per-cycle compare, directed and random stimulus.
module tb_uart_line_buffer;
  localparam int MAX_LEN = 32;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] s_axis_tdata;
  logic       s_axis_tvalid;
  logic       s_axis_tready;
  logic [7:0] m_axis_tdata;
  logic       m_axis_tvalid;
  logic       m_axis_tready;
  logic       m_axis_tlast;
  logic [7:0] echo_axis_tdata;
  logic       echo_axis_tvalid;
  logic       echo_axis_tready;
  logic       overflow;
  logic       busy;

  uart_line_buffer #(.MAX_LEN(MAX_LEN), .PTR_W(6)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast),
    .echo_axis_tdata(echo_axis_tdata), .echo_axis_tvalid(echo_axis_tvalid),
    .echo_axis_tready(echo_axis_tready),
    .overflow(overflow), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model state
  logic [8:0] exp_m[$];
  logic [7:0] exp_e[$];
  logic [7:0] line_q[$];
  bit         dropping = 0;
  bit         ovf_next = 0;
  // Captures used by the literal expectations
  logic [8:0] got_m[$];
  logic [7:0] got_e[$];
  logic [8:0] pin_m[$];
  logic [7:0] pin_e[$];
  int         ovf_seen = 0;
  bit         skip_ready = 1;
  bit         prev_stall = 0;
  logic [8:0] prev_m;

  int   m_mode = 0;   // 0 always ready, 1 random, 2 never, 3 manual
  int   e_mode = 0;
  logic m_man = 1'b0;
  logic e_man = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic echo_push(input logic [7:0] c);
`ifdef UART_LINE_ECHO_EN
    exp_e.push_back(c);
`else
    if (c === 8'hxx) exp_e.delete();
`endif
  endtask

  task automatic model_accept(input logic [7:0] c);
    bit eol;
    eol = (c == 8'h0D) || (c == 8'h0A);
    if (dropping) begin
      if (eol) begin
        dropping = 0;
        ovf_next = 1;
        line_q.delete();
      end
    end else if (c >= 8'h20 && c <= 8'h7E) begin
      if (line_q.size() < MAX_LEN) begin
        line_q.push_back(c);
        echo_push(c);
      end else begin
        dropping = 1;
      end
    end else if (c == 8'h08 || c == 8'h7F) begin
      if (line_q.size() > 0) begin
        void'(line_q.pop_back());
        echo_push(8'h08); echo_push(8'h20); echo_push(8'h08);
      end
    end else if (eol) begin
      if (line_q.size() > 0) begin
        for (int i = 0; i < line_q.size(); i++)
          exp_m.push_back({(i == line_q.size() - 1), line_q[i]});
        echo_push(8'h0D); echo_push(8'h0A);
        line_q.delete();
      end
    end
  endtask

  function automatic logic pick(input int mode, input logic man);
    case (mode)
      0: return 1'b1;
      1: return 1'($urandom_range(0, 1));
      2: return 1'b0;
      default: return man;
    endcase
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_axis_tready    = pick(m_mode, m_man);
      echo_axis_tready = pick(e_mode, e_man);
    end
  end

  // Per-cycle comparison against the model, sampled on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_m.delete(); exp_e.delete(); line_q.delete();
        dropping = 0; ovf_next = 0; skip_ready = 1; prev_stall = 0;
      end else begin
        chk("m_tvalid", m_axis_tvalid, exp_m.size() != 0);
        chk("echo_tvalid", echo_axis_tvalid, exp_e.size() != 0);
        chk("busy", busy, dropping || (exp_m.size() != 0));
        if (skip_ready) skip_ready = 0;
        else chk("s_tready", s_axis_tready, (exp_m.size() == 0) && (exp_e.size() == 0));
        chk("overflow", overflow, ovf_next);
        ovf_next = 0;
        if (overflow) ovf_seen++;
        if (prev_stall) begin
          chk("m_hold_valid", m_axis_tvalid, 1);
          chk("m_hold_data", {m_axis_tlast, m_axis_tdata}, prev_m);
        end
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_m = {m_axis_tlast, m_axis_tdata};
        if (m_axis_tvalid && m_axis_tready) begin
          got_m.push_back({m_axis_tlast, m_axis_tdata});
          if (exp_m.size() == 0) chk("m_unexpected", {m_axis_tlast, m_axis_tdata}, 9'h1FF);
          else chk("m_byte", {m_axis_tlast, m_axis_tdata}, exp_m.pop_front());
        end
        if (echo_axis_tvalid && echo_axis_tready) begin
          got_e.push_back(echo_axis_tdata);
          if (exp_e.size() == 0) chk("echo_unexpected", echo_axis_tdata, 9'h1FF);
          else chk("echo_byte", echo_axis_tdata, exp_e.pop_front());
        end
        if (s_axis_tvalid && s_axis_tready) model_accept(s_axis_tdata);
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 0;
    s_axis_tdata = b;
    s_axis_tvalid = 1'b1;
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      if (s_axis_tready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    s_axis_tvalid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int t = 0; t < 3000; t++) begin
      @(posedge clk);
      #2;
      if (exp_m.size() == 0 && exp_e.size() == 0 && !m_axis_tvalid && !echo_axis_tvalid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("idle_timeout", 0, 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic clear_caps();
    got_m.delete(); got_e.delete(); ovf_seen = 0;
  endtask

  task automatic check_pkt(input string name);
    chk({name, "_len"}, got_m.size(), pin_m.size());
    for (int i = 0; i < got_m.size() && i < pin_m.size(); i++)
      chk({name, "_byte"}, got_m[i], pin_m[i]);
  endtask

  task automatic check_echo(input string name);
`ifdef UART_LINE_ECHO_EN
    chk({name, "_len"}, got_e.size(), pin_e.size());
    for (int i = 0; i < got_e.size() && i < pin_e.size(); i++)
      chk({name, "_byte"}, got_e[i], pin_e[i]);
`else
    chk({name, "_none"}, got_e.size(), 0);
`endif
  endtask

  task automatic check_all_zero(input string name);
    chk({name, "_m_valid"}, m_axis_tvalid, 0);
    chk({name, "_m_data"}, m_axis_tdata, 0);
    chk({name, "_m_last"}, m_axis_tlast, 0);
    chk({name, "_e_valid"}, echo_axis_tvalid, 0);
    chk({name, "_e_data"}, echo_axis_tdata, 0);
    chk({name, "_ovf"}, overflow, 0);
    chk({name, "_busy"}, busy, 0);
    chk({name, "_s_ready"}, s_axis_tready, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] c;
    int r;
    s_axis_tvalid = 1'b0;
    s_axis_tdata = 8'h00;
    m_axis_tready = 1'b1;
    echo_axis_tready = 1'b1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_reset", s_axis_tready, 1);

    clear_caps();
    send_str("led1"); send_byte(8'h0D);
    wait_idle();
    pin_m = {9'h06C, 9'h065, 9'h064, 9'h131};
    pin_e = {8'h6C, 8'h65, 8'h64, 8'h31, 8'h0D, 8'h0A};
    check_pkt("led1_pkt");
    check_echo("led1_echo");

    clear_caps();
    send_str("ab"); send_byte(8'h7F); send_str("c"); send_byte(8'h0D); send_byte(8'h0A);
    wait_idle();
    pin_m = {9'h061, 9'h163};
    pin_e = {8'h61, 8'h62, 8'h08, 8'h20, 8'h08, 8'h63, 8'h0D, 8'h0A};
    check_pkt("bs_pkt");
    check_echo("bs_echo");

    clear_caps();
    for (int i = 0; i < 33; i++) send_byte(8'h41);
    send_byte(8'h0D);
    wait_idle();
    chk("ovf_no_packet", got_m.size(), 0);
    chk("ovf_pulses", ovf_seen, 1);
    clear_caps();
    send_str("x"); send_byte(8'h0D);
    wait_idle();
    pin_m = {9'h178};
    check_pkt("after_ovf_pkt");

    clear_caps();
    m_mode = 2;
    send_str("rst"); send_byte(8'h0D);
    repeat (10) @(posedge clk);
    #1;
    chk("bp_valid", m_axis_tvalid, 1);
    chk("bp_data", m_axis_tdata, 8'h72);
    chk("bp_s_ready", s_axis_tready, 0);
    chk("bp_busy", busy, 1);
    m_mode = 0;
    wait_idle();
    pin_m = {9'h072, 9'h073, 9'h174};
    check_pkt("bp_pkt");

    clear_caps();
    m_mode = 2;
    send_str("abc"); send_byte(8'h0D);
    repeat (2) @(posedge clk);
    @(negedge clk);
    #1;
    m_man = 1'b1;
    m_mode = 3;
    @(posedge clk);
    #2;
    m_man = 1'b0;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_all_zero("mid_flush_rst");
    pin_m = {9'h061};
    check_pkt("mid_flush_partial");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    m_mode = 0;
    clear_caps();
    send_str("z"); send_byte(8'h0D);
    wait_idle();
    pin_m = {9'h17A};
    check_pkt("post_rst_pkt");

    clear_caps();
`ifdef UART_LINE_ECHO_EN
    e_mode = 1;
`else
    e_mode = 2;
`endif
    send_str("hi"); send_byte(8'h0D);
    wait_idle();
    pin_m = {9'h068, 9'h169};
    check_pkt("hi_pkt");

    m_mode = 1;
    e_mode = 1;
    for (int phase = 0; phase < 2; phase++) begin
      for (int n = 0; n < 250; n++) begin
        r = $urandom_range(0, 99);
        if (r < 72) c = 8'($urandom_range(8'h20, 8'h7E));
        else if (r < 82) c = ($urandom_range(0, 1) != 0) ? 8'h08 : 8'h7F;
        else if (r < (phase == 0 ? 90 : 84)) c = ($urandom_range(0, 1) != 0) ? 8'h0D : 8'h0A;
        else begin
          case ($urandom_range(0, 3))
            0: c = 8'h01;
            1: c = 8'h1B;
            2: c = 8'h80;
            default: c = 8'hFF;
          endcase
        end
        send_byte(c);
      end
      send_byte(8'h0D);
      wait_idle();
    end
    chk("final_line_empty", line_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
